// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests a word from imem at pc, presents it to decode, follows jump/branch redirects.
// Latency: the instruction is presented the cycle after the acked edge; a single-cycle ack gives one word per 2 cycles.
// Backpressure: stall holds the presented word (and blocks the next request); a redirect overrides stall.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req/imem_addr             read request to instruction memory (addr = pc)
//   imem_ack/imem_rdata            memory response for the current request
//   stall                          decode cannot accept the presented instruction
//   pc_jump/jump_adr               unconditional redirect
//   branch_taken/branch_adr        resolved-branch redirect (wins over pc_jump)
//   instruction/instr_valid/pc_out word presented to decode and its fetch address
//   fetch_err                      sticky ack-timeout flag, cleared only by reset
module instr_fetch_unit #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_jump,
    input  logic [7:0]  jump_adr,
    input  logic        branch_taken,
    input  logic [7:0]  branch_adr,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic [7:0]  pc_out,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    // The counter is cleared on the edge where it would reach ACK_TIMEOUT,
    // so the comparison is against the value one below the limit.
    localparam logic [3:0] WAIT_LAST = 4'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  pc_out_q, pc_out_d;
    logic        err_q, err_d;
    logic [3:0]  wait_q, wait_d;

    logic        redirect;
    logic [7:0]  target;

    assign redirect = branch_taken | pc_jump;
    assign target   = branch_taken ? branch_adr : jump_adr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
            pc_out_q <= 8'h00;
            err_q    <= 1'b0;
            wait_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        err_d    = err_q;
        wait_d   = wait_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                wait_d  = 4'd0;
            end
            REQ: begin
                if (redirect) begin
                    // Any data acked this cycle belongs to the abandoned path.
                    pc_d    = target;
                    state_d = REQ;
                    wait_d  = 4'd0;
                end else if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + 8'd1;
                    state_d  = VALID;
                    wait_d   = 4'd0;
                end else if (wait_q == WAIT_LAST) begin
                    // Timeout: flag it and keep requesting the same pc.
                    err_d  = 1'b1;
                    wait_d = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = REQ;
                    wait_d  = 4'd0;
                end else if (!stall) begin
                    state_d = REQ;
                    wait_d  = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == VALID);
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios checked every cycle against a behavioural model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: stall driven directly from the scenario list.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        pc_jump;
    logic [7:0]  jump_adr;
    logic        branch_taken;
    logic [7:0]  branch_adr;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc_out;
    logic        fetch_err;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .pc_jump      (pc_jump),
        .jump_adr     (jump_adr),
        .branch_taken (branch_taken),
        .branch_adr   (branch_adr),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: "fetching" = a request is outstanding, "presenting" = decode sees a word.
    bit m_started, m_fetching, m_presenting, m_err;
    int m_pc, m_instr, m_pc_out, m_waits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_started = 0; m_fetching = 0; m_presenting = 0; m_err = 0;
        m_pc = 0; m_instr = 0; m_pc_out = 0; m_waits = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1; m_fetching = 1; m_waits = 0;
        end else if ((m_fetching || m_presenting) && (branch_taken || pc_jump)) begin
            m_pc = branch_taken ? int'(branch_adr) : int'(jump_adr);
            m_presenting = 0; m_fetching = 1; m_waits = 0;
        end else if (m_fetching) begin
            if (imem_ack) begin
                m_instr = int'(imem_rdata);
                m_pc_out = m_pc;
                m_pc = (m_pc + 1) % 256;
                m_fetching = 0; m_presenting = 1; m_waits = 0;
            end else begin
                m_waits++;
                if (m_waits == 15) begin
                    m_err = 1;
                    m_waits = 0;
                end
            end
        end else if (m_presenting && !stall) begin
            m_presenting = 0; m_fetching = 1; m_waits = 0;
        end
    endtask

    task automatic compare_all();
        chk("imem_req", imem_req, m_fetching);
        chk("instr_valid", instr_valid, m_presenting);
        chk("instruction", instruction, m_instr);
        chk("pc_out", pc_out, m_pc_out);
        chk("fetch_err", fetch_err, m_err);
        if (m_fetching) chk("imem_addr", imem_addr, m_pc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        imem_ack = 0; imem_rdata = 16'h0000; stall = 0;
        pc_jump = 0; jump_adr = 8'h00; branch_taken = 0; branch_adr = 8'h00;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        #1;
        chk("reset_req", imem_req, 0);
        chk("reset_valid", instr_valid, 0);
        chk("reset_instr", instruction, 16'h0000);
        chk("reset_pc_out", pc_out, 8'h00);
        chk("reset_err", fetch_err, 0);

        // Acks while in reset are ignored.
        imem_ack = 1; imem_rdata = 16'hDEAD;
        step(); step();
        idle_inputs();
        rst_n = 1;

        // Reset release: IDLE then first request at 00, acked immediately.
        step();
        chk("first_req_addr", imem_addr, 8'h00);
        chk("first_req", imem_req, 1);
        imem_ack = 1; imem_rdata = 16'h0512;
        step();
        imem_ack = 0;
        chk("first_instr", instruction, 16'h0512);
        chk("first_pc_out", pc_out, 8'h00);
        chk("first_valid", instr_valid, 1);

        // Stall for 3 cycles in VALID.
        stall = 1;
        repeat (3) step();
        chk("stall_valid", instr_valid, 1);
        chk("stall_req", imem_req, 0);
        chk("stall_instr", instruction, 16'h0512);
        stall = 0;
        step();
        chk("after_stall_addr", imem_addr, 8'h01);
        chk("after_stall_req", imem_req, 1);

        // Jump coinciding with an ack: data dropped.
        pc_jump = 1; jump_adr = 8'h40; imem_ack = 1; imem_rdata = 16'hBEEF;
        step();
        idle_inputs();
        chk("jump_valid", instr_valid, 0);
        chk("jump_addr", imem_addr, 8'h40);
        chk("jump_instr_kept", instruction, 16'h0512);

        imem_ack = 1; imem_rdata = 16'h1111;
        step();
        imem_ack = 0;
        chk("at40_pc_out", pc_out, 8'h40);

        // Branch and jump together while stalled: branch wins, stall overridden.
        stall = 1; branch_taken = 1; branch_adr = 8'h20; pc_jump = 1; jump_adr = 8'h40;
        step();
        idle_inputs();
        chk("branch_addr", imem_addr, 8'h20);
        chk("branch_valid", instr_valid, 0);

        // Wrap of pc from FF to 00.
        pc_jump = 1; jump_adr = 8'hFF;
        step();
        idle_inputs();
        chk("ff_addr", imem_addr, 8'hFF);
        imem_ack = 1; imem_rdata = 16'hABCD;
        step();
        imem_ack = 0;
        chk("ff_pc_out", pc_out, 8'hFF);
        step();
        chk("wrap_addr", imem_addr, 8'h00);

        // Ack timeout after 15 unacked REQ cycles.
        repeat (14) step();
        chk("pre_timeout_err", fetch_err, 0);
        step();
        chk("timeout_err", fetch_err, 1);
        chk("timeout_req", imem_req, 1);
        chk("timeout_addr", imem_addr, 8'h00);
        imem_ack = 1; imem_rdata = 16'h7777;
        step();
        imem_ack = 0;
        chk("late_instr", instruction, 16'h7777);
        chk("late_valid", instr_valid, 1);
        chk("err_sticky", fetch_err, 1);
        step();
        chk("after_late_addr", imem_addr, 8'h01);

        // Reset mid-request with an ack pending.
        imem_ack = 1; imem_rdata = 16'h5555;
        rst_n = 0;
        model_reset();
        #1;
        chk("midreset_req", imem_req, 0);
        chk("midreset_err", fetch_err, 0);
        chk("midreset_instr", instruction, 16'h0000);
        compare_all();
        step(); step();
        idle_inputs();
        rst_n = 1;
        step();
        chk("rerelease_addr", imem_addr, 8'h00);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00: program counter value loaded on reset.
REQ-002 Parameter ACK_TIMEOUT, default 15: maximum number of cycles a request waits for imem_ack before flagging an error; range 1..15.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 imem_req  output  1: instruction memory read request.
REQ-006 imem_addr  output  8: address being fetched; equals pc whenever imem_req=1.
REQ-007 imem_ack  input  1: memory has data for the current request, sampled on the rising edge.
REQ-008 imem_rdata  input  16: instruction word, valid when imem_ack=1.
REQ-009 stall  input  1: decode stage cannot accept the presented instruction.
REQ-010 pc_jump  input  1: unconditional redirect request from decode.
REQ-011 jump_adr  input  8: target address for pc_jump.
REQ-012 branch_taken  input  1: resolved-branch redirect request.
REQ-013 branch_adr  input  8: target address for branch_taken.
REQ-014 instruction  output  16: registered instruction word presented to decode.
REQ-015 instr_valid  output  1: instruction holds a live word.
REQ-016 pc_out  output  8: address the presented instruction was fetched from.
REQ-017 fetch_err  output  1: sticky flag, set when an ack timeout occurs.

Function
REQ-018 The unit SHALL use a 3-state FSM: IDLE, REQ and VALID; IDLE is entered only from reset.
REQ-019 IDLE SHALL move to REQ on the first rising edge after rst_n deasserts, with imem_req=0 throughout IDLE.
REQ-020 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-021 REQ with imem_ack=1 and no redirect SHALL, at the edge:
- capture imem_rdata into instruction;
- load pc_out with pc;
- increment pc;
- move to VALID.
REQ-022 In VALID, instr_valid SHALL be 1 and imem_req SHALL be 0.
REQ-023 VALID with stall=0 and no redirect SHALL move to REQ; VALID with stall=1 SHALL hold instruction, pc_out and instr_valid unchanged.
REQ-024 The fetch-to-present latency SHALL be 1 cycle after the acked edge; single-cycle-ack throughput SHALL be one instruction per 2 cycles.
REQ-025 Any redirect SHALL override stall.
REQ-026 Redirect in any state after IDLE, at the edge:
- load pc with the target;
- clear instr_valid;
- move to REQ;
- discard any imem_rdata acked in the same cycle.
REQ-027 If branch_taken and pc_jump are asserted together, branch_adr SHALL win over jump_adr.
REQ-028 pc increment SHALL wrap from 8'hFF to 8'h00 without error.
REQ-029 A 4-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-030 When the wait counter reaches ACK_TIMEOUT, the unit SHALL:
- set fetch_err;
- clear the counter;
- re-issue the same pc.
REQ-031 fetch_err SHALL clear only on reset.
REQ-032 Between valid periods, instruction and pc_out SHALL retain their last values.

Reset
REQ-033 On rst_n=0, the unit SHALL immediately set:
- pc=RESET_PC, state=IDLE;
- imem_req=0, instr_valid=0;
- instruction=16'h0000, pc_out=8'h00;
- fetch_err=0, wait counter=0.
REQ-034 Reset asserted mid-request SHALL abandon the request; an ack arriving while rst_n=0 SHALL be ignored.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Reset release, memory acks in the same cycle with 16'h0512 at 8'h00 -> instruction=16'h0512, pc_out=8'h00, instr_valid=1 one cycle after the ack edge; next request addresses 8'h01.
- stall=1 for 3 cycles in VALID -> instruction, pc_out and instr_valid stable, imem_req=0; first REQ follows stall release.
- pc_jump=1, jump_adr=8'h40 in the same cycle as imem_ack -> acked data dropped, instr_valid=0, next imem_addr=8'h40.
- branch_taken=1 (branch_adr=8'h20) together with pc_jump=1 (jump_adr=8'h40) -> next imem_addr=8'h20.
- Fetch at 8'hFF completes -> next imem_addr=8'h00.
- No ack for 15 REQ cycles -> fetch_err=1 and the same address is re-requested; a later ack completes normally and fetch_err stays 1.
